// File: rtl/smi_frame_arbiter_x4_pkg.sv
// ---------------------------------------------------------------------------
// smi_frame_arbiter_x4_pkg
// Shared types and helpers for the four-way SMI frame arbiter.
//   arb_state_e : arbiter FSM state encoding
//   rr_pick_t   : result of a round-robin scan (found flag + winning index)
//   rr_pick()   : round-robin scan starting one past the last grant
// Flit width and Eofc mask stay module parameters of the arbiter itself.
// ---------------------------------------------------------------------------
package smi_frame_arbiter_x4_pkg;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned EOFC_W = 8;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } rr_pick_t;

    // Scan order is last+1, last+2, last+3, last+4 (mod 4), so the most
    // recent winner has the lowest priority.
    function automatic rr_pick_t rr_pick(input logic [NUM_IN-1:0] req,
                                         input logic [1:0]        last);
        rr_pick_t   r;
        logic [1:0] idx;
        r.found = 1'b0;
        r.idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!r.found && req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/smi_frame_arbiter_x4_dbuf.sv
// ---------------------------------------------------------------------------
// smiSelfLinkDoubleBuffer
// Two-entry SMI double buffer. Stop toward the source is registered (it is
// simply "skid entry occupied"), so the buffer must absorb the one flit that
// arrives in the cycle after its output was stopped.
// Ports:
//   clk, srst            : clock, synchronous active-high reset
//   i_in_ready/i_in_data : upstream flit valid / payload
//   o_in_stop            : registered backpressure to upstream
//   o_out_ready/o_out_data : buffered flit valid / payload
//   i_out_stop           : backpressure from the consumer
// ---------------------------------------------------------------------------
module smiSelfLinkDoubleBuffer #(
    parameter int unsigned DataWidth = 136
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 i_in_ready,
    input  logic [DataWidth-1:0] i_in_data,
    output logic                 o_in_stop,
    output logic                 o_out_ready,
    output logic [DataWidth-1:0] o_out_data,
    input  logic                 i_out_stop
);

    logic                 r_main_valid;
    logic                 r_skid_valid;
    logic [DataWidth-1:0] r_main_data;
    logic [DataWidth-1:0] r_skid_data;
    logic                 w_accept;
    logic                 w_drain;

    assign w_accept = i_in_ready & ~r_skid_valid;
    assign w_drain  = r_main_valid & ~i_out_stop;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // Full: upstream is stopped, only the skid entry can move forward.
            if (w_drain) begin
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_drain) begin
                r_main_valid <= 1'b1;
            end else begin
                r_skid_valid <= 1'b1;
            end
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (r_skid_valid) begin
            if (w_drain) begin
                r_main_data <= r_skid_data;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_drain) begin
                r_main_data <= i_in_data;
            end else begin
                r_skid_data <= i_in_data;
            end
        end
    end

    assign o_in_stop   = r_skid_valid;
    assign o_out_ready = r_main_valid;
    assign o_out_data  = r_main_data;

endmodule

// File: rtl/smi_frame_arbiter_x4.sv
// ---------------------------------------------------------------------------
// smi_frame_arbiter_x4
// Merges four SMI inputs (A..D) onto one SMI output with frame-atomic
// round-robin arbitration. Each input passes through a double buffer; the
// arbiter picks a buffered frame and forwards all of its flits through a
// single output register before looking at another input.
// Ports:
//   clk, srst                 : clock, synchronous active-high reset
//   smiIn{A..D}Ready/Eofc/Data : input flit valid, end-of-frame ctrl, payload
//   smiIn{A..D}Stop            : registered backpressure to each source
//   smiOutReady/Eofc/Data      : output flit valid, masked Eofc, payload
//   smiOutStop                 : backpressure from downstream
//
// state      | meaning
// -----------+----------------------------------------------------------
// ARB_IDLE   | no frame in progress; round-robin scan picks a winner
// ARB_LOCKED | mid-frame on r_lock_idx; only that buffer may drain
// ---------------------------------------------------------------------------
module smi_frame_arbiter_x4
    import smi_frame_arbiter_x4_pkg::*;
#(
    parameter int unsigned FlitWidth = 16
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   smiInAReady,
    input  logic [7:0]             smiInAEofc,
    input  logic [FlitWidth*8-1:0] smiInAData,
    output logic                   smiInAStop,
    input  logic                   smiInBReady,
    input  logic [7:0]             smiInBEofc,
    input  logic [FlitWidth*8-1:0] smiInBData,
    output logic                   smiInBStop,
    input  logic                   smiInCReady,
    input  logic [7:0]             smiInCEofc,
    input  logic [FlitWidth*8-1:0] smiInCData,
    output logic                   smiInCStop,
    input  logic                   smiInDReady,
    input  logic [7:0]             smiInDEofc,
    input  logic [FlitWidth*8-1:0] smiInDData,
    output logic                   smiInDStop,
    output logic                   smiOutReady,
    output logic [7:0]             smiOutEofc,
    output logic [FlitWidth*8-1:0] smiOutData,
    input  logic                   smiOutStop
);

    localparam int unsigned DataW     = FlitWidth * 8;
    localparam int unsigned WordW     = DataW + EOFC_W;
    localparam int unsigned EofcMask  = 2 * FlitWidth - 1;
    localparam logic [7:0]  EofcMask8 = 8'(EofcMask);

    logic [NUM_IN-1:0] w_in_ready;
    logic [WordW-1:0]  w_in_word [NUM_IN];
    logic [NUM_IN-1:0] w_in_stop;

    logic [NUM_IN-1:0] w_buf_ready;
    logic [WordW-1:0]  w_buf_word [NUM_IN];
    logic [NUM_IN-1:0] w_buf_stop;

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [1:0]        r_lock_idx;
    logic [1:0]        w_lock_nxt;
    logic [1:0]        r_last_grant;
    logic [1:0]        w_last_nxt;

    rr_pick_t          w_pick;
    logic [1:0]        w_sel_idx;
    logic              w_sel_valid;
    logic [WordW-1:0]  w_sel_word;
    logic              w_sel_last;
    logic              w_out_load;
    logic              w_xfer;

    logic              r_out_valid;
    logic [7:0]        r_out_eofc;
    logic [DataW-1:0]  r_out_data;

    assign w_in_ready   = {smiInDReady, smiInCReady, smiInBReady, smiInAReady};
    assign w_in_word[0] = {smiInAEofc, smiInAData};
    assign w_in_word[1] = {smiInBEofc, smiInBData};
    assign w_in_word[2] = {smiInCEofc, smiInCData};
    assign w_in_word[3] = {smiInDEofc, smiInDData};

    assign smiInAStop = w_in_stop[0];
    assign smiInBStop = w_in_stop[1];
    assign smiInCStop = w_in_stop[2];
    assign smiInDStop = w_in_stop[3];

    for (genvar g = 0; g < NUM_IN; g++) begin : g_buf
        smiSelfLinkDoubleBuffer #(
            .DataWidth (WordW)
        ) u_dbuf (
            .clk         (clk),
            .srst        (srst),
            .i_in_ready  (w_in_ready[g]),
            .i_in_data   (w_in_word[g]),
            .o_in_stop   (w_in_stop[g]),
            .o_out_ready (w_buf_ready[g]),
            .o_out_data  (w_buf_word[g]),
            .i_out_stop  (w_buf_stop[g])
        );
    end

    always_comb begin
        w_pick      = rr_pick(w_buf_ready, r_last_grant);
        w_out_load  = ~r_out_valid | ~smiOutStop;
        w_sel_idx   = w_pick.idx;
        w_sel_valid = w_pick.found;
        if (r_state == ARB_LOCKED) begin
            w_sel_idx   = r_lock_idx;
            w_sel_valid = w_buf_ready[r_lock_idx];
        end
        w_sel_word = w_buf_word[w_sel_idx];
        w_sel_last = (w_sel_word[WordW-1 -: EOFC_W] != 8'd0);
        w_xfer     = w_sel_valid & w_out_load;

        w_state_nxt = r_state;
        w_lock_nxt  = r_lock_idx;
        w_last_nxt  = r_last_grant;
        if (w_sel_valid) begin
            if (w_xfer && w_sel_last) begin
                w_state_nxt = ARB_IDLE;
                w_last_nxt  = w_sel_idx;
            end else begin
                // A win in IDLE locks even if the output is stalled this cycle,
                // so a later requester cannot steal the grant.
                w_state_nxt = ARB_LOCKED;
                w_lock_nxt  = w_sel_idx;
            end
        end

        // Only the selected buffer drains, and only when the output can take it.
        for (int i = 0; i < NUM_IN; i++) begin
            w_buf_stop[i] = ~(w_xfer && (w_sel_idx == 2'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state      <= ARB_IDLE;
            r_lock_idx   <= 2'd0;
            r_last_grant <= 2'd3;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_idx   <= w_lock_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_out_valid <= 1'b0;
        end else if (w_out_load) begin
            r_out_valid <= w_xfer;
        end
    end

    always_ff @(posedge clk) begin
        if (w_out_load) begin
            r_out_data <= w_sel_word[DataW-1:0];
            r_out_eofc <= w_sel_word[WordW-1 -: EOFC_W] & EofcMask8;
        end
    end

    assign smiOutReady = r_out_valid;
    assign smiOutEofc  = r_out_eofc;
    assign smiOutData  = r_out_data;

endmodule

// File: tb/tb_smi_frame_arbiter_x4.sv
module tb_smi_frame_arbiter_x4;

    localparam int         FW   = 16;
    localparam int         DW   = FW * 8;
    localparam logic [7:0] MASK = 8'h1F;

    typedef struct packed {
        logic [7:0]    eofc;
        logic [DW-1:0] data;
    } flit_t;

    logic          clk = 1'b0;
    logic          srst;
    logic [3:0]    in_ready;
    logic [7:0]    in_eofc [4];
    logic [DW-1:0] in_data [4];
    logic [3:0]    in_stop;
    logic          out_ready;
    logic [7:0]    out_eofc;
    logic [DW-1:0] out_data;
    logic          out_stop;

    always #5 clk = ~clk;

    smi_frame_arbiter_x4 #(.FlitWidth(FW)) dut (
        .clk         (clk),
        .srst        (srst),
        .smiInAReady (in_ready[0]), .smiInAEofc (in_eofc[0]), .smiInAData (in_data[0]), .smiInAStop (in_stop[0]),
        .smiInBReady (in_ready[1]), .smiInBEofc (in_eofc[1]), .smiInBData (in_data[1]), .smiInBStop (in_stop[1]),
        .smiInCReady (in_ready[2]), .smiInCEofc (in_eofc[2]), .smiInCData (in_data[2]), .smiInCStop (in_stop[2]),
        .smiInDReady (in_ready[3]), .smiInDEofc (in_eofc[3]), .smiInDData (in_data[3]), .smiInDStop (in_stop[3]),
        .smiOutReady (out_ready),
        .smiOutEofc  (out_eofc),
        .smiOutData  (out_data),
        .smiOutStop  (out_stop)
    );

    int n_pass = 0;
    int n_tot  = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    endfunction

    // ---------------- reference model: per-input buffer queues ----------------
    flit_t mq [4][$];
    bit    m_out_v  = 1'b0;
    flit_t m_out;
    bit    m_locked = 1'b0;
    int    m_lock   = 0;
    int    m_last   = 3;
    bit    acc [4];

    always @(posedge clk) begin
        bit    stop_pre [4];
        bit    loadable;
        bit    avail;
        int    sel;
        flit_t h;
        for (int i = 0; i < 4; i++) begin
            stop_pre[i] = (mq[i].size() == 2);
            acc[i] = 1'b0;
        end
        if (srst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            m_out_v  = 1'b0;
            m_locked = 1'b0;
            m_last   = 3;
        end else begin
            loadable = !m_out_v || !out_stop;
            avail = 1'b0;
            sel = 0;
            if (m_locked) begin
                sel = m_lock;
                avail = (mq[sel].size() > 0);
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (!avail && mq[(m_last + k) % 4].size() > 0) begin
                        sel = (m_last + k) % 4;
                        avail = 1'b1;
                    end
                end
            end
            if (avail && loadable) begin
                h = mq[sel].pop_front();
                m_out_v = 1'b1;
                m_out = h;
                if (h.eofc != 8'd0) begin
                    m_locked = 1'b0;
                    m_last = sel;
                end else begin
                    m_locked = 1'b1;
                    m_lock = sel;
                end
            end else if (avail) begin
                m_locked = 1'b1;
                m_lock = sel;
            end else if (loadable) begin
                m_out_v = 1'b0;
            end
            for (int i = 0; i < 4; i++) begin
                if (in_ready[i] && !stop_pre[i]) begin
                    mq[i].push_back({in_eofc[i], in_data[i]});
                    acc[i] = 1'b1;
                end
            end
        end
        #1;
        chk("cyc_out_ready", out_ready, m_out_v);
        if (m_out_v) begin
            chk("cyc_out_data", out_data, m_out.data);
            chk("cyc_out_eofc", out_eofc, m_out.eofc & MASK);
        end
        for (int i = 0; i < 4; i++) chk($sformatf("cyc_stop_%0d", i), in_stop[i], mq[i].size() == 2);
    end

    // ---------------- source driver ----------------
    int         pct [4];
    bit         gen_on [4];
    int         fixlen [4];
    logic [7:0] fix_eofc [4];
    int         pos [4];
    int         flen [4];
    int         seq [4];

    task automatic drive_step();
        logic [95:0] rnd;
        for (int i = 0; i < 4; i++) begin
            if (in_ready[i] && !acc[i]) continue;
            in_ready[i] = 1'b0;
            if (pos[i] == 0 && !gen_on[i]) continue;
            if ($urandom_range(99) >= pct[i]) continue;
            if (pos[i] == 0) flen[i] = (fixlen[i] != 0) ? fixlen[i] : int'($urandom_range(4, 1));
            rnd = {$urandom(), $urandom(), $urandom()};
            in_data[i] = {8'(160 + i), 32'(seq[i]), rnd[87:0]};
            seq[i]++;
            pos[i]++;
            if (pos[i] == flen[i]) begin
                in_eofc[i] = (fix_eofc[i] != 8'd0) ? fix_eofc[i] : 8'($urandom_range(255, 1));
                pos[i] = 0;
            end else begin
                in_eofc[i] = 8'd0;
            end
            in_ready[i] = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drive_step();
    endtask

    task automatic do_reset(input int n);
        srst = 1'b1;
        out_stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_ready[i] = 1'b0;
            pos[i] = 0;
            gen_on[i] = 1'b0;
        end
        repeat (n) @(negedge clk);
        srst = 1'b0;
    endtask

    task automatic cfg(input int i, input int p, input int len, input logic [7:0] e);
        pct[i] = p;
        fixlen[i] = len;
        fix_eofc[i] = e;
        gen_on[i] = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 4; i++) gen_on[i] = 1'b0;
        out_stop = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        int  base;
        bit  drained;
        srst = 1'b1;
        out_stop = 1'b0;
        in_ready = 4'b0;
        for (int i = 0; i < 4; i++) begin
            in_eofc[i] = 8'd0;
            in_data[i] = '0;
            pct[i] = 100;
            gen_on[i] = 1'b0;
            fixlen[i] = 0;
            fix_eofc[i] = 8'd0;
            pos[i] = 0;
            flen[i] = 1;
            seq[i] = 0;
        end

        // reset state
        do_reset(3);
        chk("rst_out_ready", out_ready, 1'b0);
        chk("rst_stops", in_stop, 4'b0);

        // single 3-flit frame on B, Eofc 0,0,16
        cfg(1, 100, 3, 8'd16);
        tick(); gen_on[1] = 1'b0;
        @(posedge clk); #1; chk("sf_lat_t1_ready", out_ready, 1'b0);
        tick();
        @(posedge clk); #1; chk("sf_f0_ready", out_ready, 1'b1); chk("sf_f0_src", out_data[DW-1 -: 8], 8'hA1); chk("sf_f0_eofc", out_eofc, 8'd0);
        tick();
        @(posedge clk); #1; chk("sf_f1_src", out_data[DW-1 -: 8], 8'hA1); chk("sf_f1_eofc", out_eofc, 8'd0);
        tick();
        @(posedge clk); #1; chk("sf_f2_src", out_data[DW-1 -: 8], 8'hA1); chk("sf_f2_eofc", out_eofc, 8'd16);
        tick();
        @(posedge clk); #1; chk("sf_after_ready", out_ready, 1'b0);

        // Eofc masking: 0xFF -> 0x1F
        cfg(0, 100, 1, 8'hFF);
        tick(); gen_on[0] = 1'b0;
        @(posedge clk);
        tick();
        @(posedge clk); #1; chk("mask_ready", out_ready, 1'b1); chk("mask_eofc", out_eofc, 8'h1F);
        drain(4);

        // all four inputs contend from reset with 2-flit frames
        do_reset(2);
        for (int i = 0; i < 4; i++) cfg(i, 100, 2, 8'h02);
        tick();
        for (int i = 0; i < 4; i++) gen_on[i] = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 8; k++) begin
            tick();
            @(posedge clk); #1;
            chk($sformatf("ct_ready_%0d", k), out_ready, 1'b1);
            chk($sformatf("ct_src_%0d", k), out_data[DW-1 -: 8], 8'(8'hA0 + k / 2));
            chk($sformatf("ct_eofc_%0d", k), out_eofc, (k % 2 == 1) ? 8'h02 : 8'h00);
        end
        tick();
        @(posedge clk); #1; chk("ct_after_ready", out_ready, 1'b0);
        drain(3);

        // continuous single-flit frames on A and C alternate
        do_reset(2);
        cfg(0, 100, 1, 8'h04);
        cfg(2, 100, 1, 8'h04);
        tick();
        @(posedge clk);
        tick();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sfl_ready_%0d", k), out_ready, 1'b1);
            chk($sformatf("sfl_src_%0d", k), out_data[DW-1 -: 8], (k % 2 == 0) ? 8'hA0 : 8'hA2);
            tick();
        end
        drain(12);

        // output backpressure mid-frame on D
        base = seq[3];
        cfg(3, 100, 10, 8'h80);
        tick(); gen_on[3] = 1'b0;
        repeat (3) begin @(posedge clk); tick(); end
        out_stop = 1'b1;
        @(posedge clk); #1; chk("bp_hold_ready", out_ready, 1'b1);
        tick();
        @(posedge clk); #1; chk("bp_stop_d", in_stop[3], 1'b1);
        repeat (3) begin tick(); @(posedge clk); end
        tick();
        out_stop = 1'b0;
        @(posedge clk); #1;
        chk("bp_resume_src", out_data[DW-1 -: 8], 8'hA3);
        chk("bp_resume_seq", out_data[DW-9 -: 32], 32'(base + 2));
        drain(20);

        // reset mid-frame on A, then B is granted before A
        cfg(0, 100, 8, 8'h01);
        tick(); gen_on[0] = 1'b0;
        repeat (4) begin @(posedge clk); tick(); end
        do_reset(1);
        chk("mrst_ready", out_ready, 1'b0);
        chk("mrst_stops", in_stop, 4'b0);
        cfg(1, 100, 1, 8'h03);
        tick(); gen_on[1] = 1'b0;
        cfg(0, 100, 1, 8'h03);
        tick(); gen_on[0] = 1'b0;
        @(posedge clk); #1; chk("mrst_first_src", out_data[DW-1 -: 8], 8'hA1);
        tick();
        @(posedge clk); #1; chk("mrst_second_src", out_data[DW-1 -: 8], 8'hA0);
        drain(4);

        // randomized traffic with random downstream stalls and one reset
        for (int phase = 0; phase < 2; phase++) begin
            do_reset(2);
            for (int i = 0; i < 4; i++) cfg(i, int'($urandom_range(100, 30)), 0, 8'd0);
            repeat (1500) begin
                tick();
                out_stop = ($urandom_range(99) < 25);
            end
        end
        for (int i = 0; i < 4; i++) gen_on[i] = 1'b0;
        out_stop = 1'b0;
        drained = 1'b0;
        for (int k = 0; k < 200 && !drained; k++) begin
            tick();
            if (mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 &&
                mq[3].size() == 0 && !m_out_v && in_ready == 4'b0) drained = 1'b1;
        end
        chk("drain_done", drained, 1'b1);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
